// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the debug message sources, the arbiter and the UART.
// The requester/UART side uses the master modport; the arbiter uses slave.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ*8-1:0] req_dat;
    logic [N_REQ-1:0]   req_val;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_rdy;
    logic [N_REQ-1:0]   grant;
    logic [7:0]         uart_txd;
    logic               uart_txv;
    logic               uart_cts;
    logic               busy;
    logic               err;

    modport master (
        output req_dat, req_val, req_last, uart_cts,
        input  req_rdy, uart_txd, uart_txv, grant, busy, err
    );

    modport slave (
        input  req_dat, req_val, req_last, uart_cts,
        output req_rdy, uart_txd, uart_txv, grant, busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the debug UART transmitter between N_REQ message
// sources; one grant per message, optional LF,CR terminator after each message.
//
//   state     | meaning
//   S_IDLE    | no owner, scan requests from rr_ptr
//   S_SEND    | forward bytes of the granted source
//   S_TERM    | message done (last, truncated or stalled), send LF
//   S_CR      | send CR
//   S_RELEASE | drop grant, advance rr_ptr past the owner
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MAX_MSG_LEN = 64,
    parameter int STALL_TICKS = 1024,
    parameter int APPEND_CRLF = 1
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_MSG_LEN + 1);
    localparam int SW = $clog2(STALL_TICKS + 1);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(MAX_MSG_LEN - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TICKS - 1);
    localparam logic [PW-1:0] IDX_LAST   = PW'(N_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_TERM, S_CR, S_RELEASE} state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] grant, grant_nxt;
    logic [PW-1:0]    gidx, gidx_nxt;
    logic [PW-1:0]    rr_ptr, rr_nxt;
    logic [BW-1:0]    byte_cnt, byte_nxt;
    logic [SW-1:0]    stall_cnt, stall_nxt;
    logic [7:0]       txd, txd_nxt;
    logic             txv, txv_nxt;
    logic             err, err_nxt;

    logic [PW:0]      rr_sum;
    logic [PW-1:0]    pick;
    logic             pick_found;
    logic             can_send;

    assign can_send     = bus.uart_cts && !txv;
    assign bus.req_rdy  = (state == S_SEND && can_send) ? grant : '0;
    assign bus.grant    = grant;
    assign bus.uart_txd = txd;
    assign bus.uart_txv = txv;
    assign bus.busy     = (state != S_IDLE);
    assign bus.err      = err;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        rr_sum     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (rr_sum >= (PW+1)'(N_REQ)) rr_sum = rr_sum - (PW+1)'(N_REQ);
            if (!pick_found && bus.req_val[rr_sum[PW-1:0]]) begin
                pick_found = 1'b1;
                pick       = rr_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        rr_nxt    = rr_ptr;
        byte_nxt  = byte_cnt;
        stall_nxt = stall_cnt;
        txd_nxt   = txd;
        txv_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                    gidx_nxt  = pick;
                    byte_nxt  = '0;
                    stall_nxt = '0;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.req_val[gidx]) begin
                    if (can_send) begin
                        txd_nxt   = bus.req_dat[8*gidx +: 8];
                        txv_nxt   = 1'b1;
                        byte_nxt  = byte_cnt + 1'b1;
                        stall_nxt = '0;
                        if (bus.req_last[gidx]) begin
                            state_nxt = S_TERM;
                        end else if (byte_cnt == BYTE_LAST) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_TERM;
                        end
                    end
                end else if (stall_cnt == STALL_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_TERM;
                end else begin
                    stall_nxt = stall_cnt + 1'b1;
                end
            end
            S_TERM: begin
                if (APPEND_CRLF == 0) begin
                    state_nxt = S_RELEASE;
                end else if (can_send) begin
                    txd_nxt   = 8'h0a;
                    txv_nxt   = 1'b1;
                    state_nxt = S_CR;
                end
            end
            S_CR: begin
                if (can_send) begin
                    txd_nxt   = 8'h0d;
                    txv_nxt   = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                grant_nxt = '0;
                rr_nxt    = (gidx == IDX_LAST) ? '0 : gidx + 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            byte_cnt  <= '0;
            stall_cnt <= '0;
            txd       <= 8'h00;
            txv       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            gidx      <= gidx_nxt;
            rr_ptr    <= rr_nxt;
            byte_cnt  <= byte_nxt;
            stall_cnt <= stall_nxt;
            txd       <= txd_nxt;
            txv       <= txv_nxt;
            err       <= err_nxt;
        end
    end
endmodule
